// File: rtl/imem_pipe.sv
// imem_pipe: run-time loadable instruction memory with a LAT-stage stallable fetch pipeline
module imem_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 32,
  parameter int LAT = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              pc,
  input  logic                     stall,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        inst,
  output logic [1:0]               fault,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};
  logic [LAT-1:0] v;
  logic [DATA_W-1:0] d [LAT];
  logic [1:0] f [LAT];
  logic [1:0] flt;
  logic [DATA_W-1:0] rd;
  assign req_ready = !stall;
  assign rsp_valid = v[LAT-1];
  assign inst = d[LAT-1];
  assign fault = f[LAT-1];
  // range check on the full pc before truncating to a word index, so high addresses never alias
  always_comb begin
    flt = {pc[31:2+AW] != '0, pc[1:0] != 2'b00};
    rd = (flt != 2'b00) ? NOP_WORD : mem[pc[AW+1:2]];
  end
  // program load port; the fetch path sees the pre-write word in the same cycle
  always_ff @(posedge clk)
    if (!rst && prog_we) mem[prog_addr] <= prog_data;
  // fetch pipeline: stage data only advances behind a valid, so outputs hold across bubbles
  always_ff @(posedge clk)
    if (rst) begin
      v <= '0;
      for (int k = 0; k < LAT; k++) begin
        d[k] <= NOP_WORD;
        f[k] <= 2'b00;
      end
    end else if (!stall) begin
      v[0] <= req_valid;
      if (req_valid) begin
        d[0] <= rd;
        f[0] <= flt;
      end
      for (int k = 1; k < LAT; k++) begin
        v[k] <= v[k-1];
        if (v[k-1]) begin
          d[k] <= d[k-1];
          f[k] <= f[k-1];
        end
      end
    end
endmodule

// File: doc/imem_pipe.md
Name: imem_pipe

Overview:
- Parametrised instruction memory for the pipelined CPU datapath; it is the next generation of the fixed 32x32 single-cycle instruction memory.
- The PC side uses a valid/ready fetch port with configurable read latency and a stall input.
- Out-of-range and misaligned fetches are flagged as faults and return NOP.
- A separate write port loads programs at run time, so contents no longer have to be hard-coded.

Parameters:
- DATA_W, 32, instruction width in bits.
- DEPTH, 32, number of instruction words; power of two, range 2..1024.
- LAT, 1, fetch latency in cycles from request accept to rsp_valid; legal range 1..4.
- NOP_WORD, 32'h00000000, word returned on fault and driven on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  fetch request can be accepted this cycle.
- pc  in  32  byte address of the fetch.
- stall  in  1  freezes the fetch pipeline and output.
- rsp_valid  out  1  inst and fault are valid this cycle.
- inst  out  DATA_W  fetched instruction.
- fault  out  2  bit0 = misaligned (pc[1:0]!=0), bit1 = out of range (pc>>2 >= DEPTH).
- prog_we  in  1  program-load write enable.
- prog_addr  in  $clog2(DEPTH)  word index for the write.
- prog_data  in  DATA_W  word to write.

Behaviour:
- Reset (rst high at a posedge): all pipeline valid bits clear; rsp_valid=0, inst=NOP_WORD, fault=0. Memory contents are not cleared.
  - Reset takes priority over stall, req and prog_we in the same cycle. A write coinciding with reset is dropped.
  - In-flight fetches are discarded; no response appears after reset deasserts.
- Memory initial contents: all words NOP_WORD at time zero.
- Handshake:
  - req_ready = !stall (combinational); independent of rst level.
  - A fetch is accepted on a posedge with req_valid && req_ready && !rst.
  - pc is sampled only on accept; pc may change freely otherwise.
- Pipeline: LAT stages, each holding valid, data and fault.
  - Stage 1 captures the memory word at index pc[2+$clog2(DEPTH)-1:2] plus the fault bits.
  - Each subsequent stage shifts by one per unstalled cycle.
  - The last stage drives rsp_valid, inst and fault.
  - A fetch accepted at edge N gives rsp_valid=1 from edge N+LAT-1 onward, i.e. visible in the cycle after edge N+LAT-1 (LAT=1: visible the cycle after accept).
  - One fetch per cycle, full throughput; back-to-back fetches give back-to-back responses.
  - Cycles with no accept insert bubbles (valid=0). When rsp_valid=0, inst holds its last value.
- Stall: while stall=1, every stage including the output holds its value and no fetch is accepted. After stall drops, the pipeline resumes exactly where it left off; no response is lost or duplicated.
- Faults:
  - If either fault bit is set, stage 1 captures NOP_WORD instead of memory data.
  - Both bits may be set together.
  - Fault travels with its instruction and is meaningful only when rsp_valid=1.
  - Out-of-range check uses the full 32-bit pc: any pc>=4*DEPTH faults. No wrap-around.
- Program write: on a posedge with prog_we=1 and !rst, mem[prog_addr] <= prog_data. Writes proceed regardless of stall.
- Write/read same word in the same cycle: the fetch captures the OLD contents (read-before-write). The new value is seen by fetches accepted at the next edge or later.
- Arithmetic: word index = pc>>2, truncated to $clog2(DEPTH) bits only after the range check.

Test Plan:
- LAT=1, DEPTH=32. After reset, preload words 3..5 via prog_we with 32'h8C110008, 32'h8C120004, 32'h02324020. Fetch pc=12,16,20 back-to-back -> rsp_valid high for 3 consecutive cycles starting the cycle after the first accept, inst = those three words in order, fault=0.
- LAT=3, fetch pc=0,4 with a 1-cycle bubble between -> responses 3 cycles after each accept with a rsp_valid=0 gap between them. Assert stall for 2 cycles mid-flight -> outputs frozen, both responses still delivered once each, each delayed by 2 cycles.
- Fault cases:
  - pc=6 -> inst=NOP_WORD, fault=2'b01.
  - pc=128 with DEPTH=32 -> fault=2'b10.
  - pc=130 -> fault=2'b11.
  - pc=32'hFFFFFFFC -> fault=2'b10, with no alias to word 31.
- Same-cycle hazard: mem[7]=A; in one cycle prog_we to index 7 with value B and fetch pc=28 -> response inst=A. Fetch pc=28 again -> inst=B.
- Reset mid-operation, LAT=2: two fetches in flight, rst pulsed 1 cycle -> rsp_valid stays 0 afterwards, inst=NOP_WORD, fault=0. Memory retains the preloaded words, confirmed by a subsequent fetch.
